// File: rtl/nvdla_dbb_stream_arbiter.sv
// N-channel round-robin packet arbiter with per-channel FIFOs.
// Grants last a whole packet or MAX_BURST beats, whichever ends first.
module nvdla_dbb_stream_arbiter #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 16,
  localparam int IDW = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic [N_CH-1:0]            in_valid_i,
  output logic [N_CH-1:0]            in_ready_o,
  input  logic [N_CH*DATA_WIDTH-1:0] in_data_i,
  input  logic [N_CH-1:0]            in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic                       out_last_o,
  output logic [IDW-1:0]             out_id_o,
  output logic                       busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  logic [DATA_WIDTH:0] mem_q [N_CH][FIFO_DEPTH];
  logic [AW:0]         wp_q  [N_CH];
  logic [AW:0]         rp_q  [N_CH];
  logic [DATA_WIDTH:0] head  [N_CH];
  logic [N_CH-1:0]     empty, full, push, pop;
  logic                flush;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ov_q, ov_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic                ol_q, ol_d;
  logic [IDW-1:0]      oid_q, oid_d;

  assign flush = rst_i | clear_i;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      empty[c] = wp_q[c] == rp_q[c];
      full[c]  = (wp_q[c][AW] != rp_q[c][AW]) &&
                 (wp_q[c][AW-1:0] == rp_q[c][AW-1:0]);
      head[c]  = mem_q[c][rp_q[c][AW-1:0]];
    end
  end

  assign in_ready_o = ~full;
  assign push       = in_valid_i & ~full;

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_CH; c++) begin
      if (push[c]) begin
        mem_q[c][wp_q[c][AW-1:0]] <=
          {in_data_i[c*DATA_WIDTH +: DATA_WIDTH], in_last_i[c]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N_CH; c++) begin
      if (flush) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
      end else begin
        if (push[c]) wp_q[c] <= wp_q[c] + 1'b1;
        if (pop[c])  rp_q[c] <= rp_q[c] + 1'b1;
      end
    end
  end

  logic           load_ok, found, last_v;
  logic [IDW-1:0] sel, idx;
  logic [CW-1:0]  cnt_nx;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    oid_d   = oid_q;
    pop     = '0;
    found   = 1'b0;
    sel     = ptr_q;
    idx     = ptr_q;
    last_v  = 1'b0;
    load_ok = !ov_q || out_ready_i;
    cnt_nx  = (state_q == LOCKED) ? cnt_q + 1'b1 : CW'(1);
    if (enable_i && load_ok) begin
      unique case (state_q)
        IDLE: begin
          // search starts one past the last grant for fairness
          for (int i = 1; i <= N_CH; i++) begin
            idx = IDW'((int'(ptr_q) + i) % N_CH);
            if (!found && !empty[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
        end
        LOCKED: begin
          if (!empty[ptr_q]) begin
            found = 1'b1;
            sel   = ptr_q;
          end
        end
      endcase
    end
    if (found) begin
      pop[sel] = 1'b1;
      last_v   = head[sel][0] || (cnt_nx == CW'(MAX_BURST));
      ptr_d    = sel;
      cnt_d    = cnt_nx;
      ov_d     = 1'b1;
      od_d     = head[sel][DATA_WIDTH:1];
      ol_d     = last_v;
      oid_d    = sel;
      state_d  = last_v ? IDLE : LOCKED;
    end else if (load_ok) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(N_CH - 1);
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      oid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      oid_q   <= oid_d;
    end
  end

  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_last_o  = ol_q;
  assign out_id_o    = oid_q;
  assign busy_o      = (|(~empty)) || ov_q || (state_q == LOCKED);

endmodule

// File: tb/tb_nvdla_dbb_stream_arbiter.sv
// Randomized bench for nvdla_dbb_stream_arbiter against a queue-based
// cycle model of the arbitration rules.
module tb_nvdla_dbb_stream_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int MB  = 16;
  localparam int IDW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst, clr, en, ordy;
  logic [N-1:0]      vld, lst, in_ready;
  logic [N*DW-1:0]   dat;
  logic              out_valid, out_last, busy;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;

  nvdla_dbb_stream_arbiter #(
    .N_CH(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .MAX_BURST(MB)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
    .in_valid_i(vld), .in_ready_o(in_ready), .in_data_i(dat),
    .in_last_i(lst), .out_valid_o(out_valid), .out_ready_i(ordy),
    .out_data_o(out_data), .out_last_o(out_last), .out_id_o(out_id),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  beat_t         mq[N][$];
  bit            m_valid, m_last, m_lock;
  logic [DW-1:0] m_data;
  int            m_id, m_ptr, m_cnt;

  task automatic model_step();
    bit    rdy[N];
    bit    lo;
    int    sel;
    beat_t b;
    if (rst || clr) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      m_valid = 0; m_last = 0; m_lock = 0;
      m_data = '0; m_id = 0; m_ptr = N - 1; m_cnt = 0;
      return;
    end
    for (int c = 0; c < N; c++) rdy[c] = mq[c].size() < DEP;
    lo  = !m_valid || ordy;
    sel = -1;
    if (en && lo) begin
      if (m_lock) begin
        if (mq[m_ptr].size() > 0) sel = m_ptr;
      end else begin
        for (int k = 1; k <= N; k++)
          if (sel < 0 && mq[(m_ptr + k) % N].size() > 0)
            sel = (m_ptr + k) % N;
      end
    end
    if (sel >= 0) begin
      b       = mq[sel].pop_front();
      m_cnt   = m_lock ? m_cnt + 1 : 1;
      m_ptr   = sel;
      m_valid = 1;
      m_data  = b.d;
      m_id    = sel;
      m_last  = b.l || (m_cnt == MB);
      m_lock  = !m_last;
    end else if (lo) begin
      m_valid = 0;
    end
    for (int c = 0; c < N; c++)
      if (vld[c] && rdy[c]) mq[c].push_back({dat[c*DW +: DW], lst[c]});
  endtask

  task automatic compare_all();
    logic [N-1:0] er;
    bit           eb;
    eb = m_valid || m_lock;
    for (int c = 0; c < N; c++) begin
      er[c] = mq[c].size() < DEP;
      if (mq[c].size() > 0) eb = 1;
    end
    chk("in_ready",  64'(in_ready),  64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data",  64'(out_data),  64'(m_data));
    chk("out_last",  64'(out_last),  64'(m_last));
    chk("out_id",    64'(out_id),    64'(m_id));
    chk("busy",      64'(busy),      64'(eb));
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  initial begin
    int pv, pr, pe, pl, pc;
    rst = 1; clr = 0; en = 1; ordy = 1;
    vld = '0; lst = '0; dat = '0;
    model_step();
    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(negedge clk);
      compare_all();
      case ((cyc / 400) % 7)
        0: begin pv = 100; pr = 100; pe = 100; pl = 100; pc = 0; end
        1: begin pv = 30;  pr = 100; pe = 100; pl = 50;  pc = 0; end
        2: begin pv = 90;  pr = 100; pe = 100; pl = 3;   pc = 0; end
        3: begin pv = 70;  pr = 30;  pe = 100; pl = 30;  pc = 0; end
        4: begin pv = 60;  pr = 80;  pe = 50;  pl = 20;  pc = 0; end
        default: begin pv = 80; pr = 70; pe = 90; pl = 10; pc = 2; end
      endcase
      rst  = (cyc < 1) || (pc > 0 && pct(1));
      clr  = pc > 0 && pct(pc);
      en   = pct(pe);
      ordy = pct(pr);
      for (int c = 0; c < N; c++) begin
        vld[c]         = pct(pv);
        lst[c]         = pct(pl);
        dat[c*DW +: DW] = $urandom;
      end
      model_step();
    end
    @(negedge clk);
    compare_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nvdla_dbb_stream_arbiter.md
Name: nvdla_dbb_stream_arbiter

Overview:
- Parametrised N-channel packet arbiter that merges several DBB-side streams into one stream toward the streamer/TCDM path.
- Successor to the single-channel dbb wiring in the accelerator top level.
- Each input channel is buffered in its own FIFO; channels are granted round-robin.
- A grant is held for a whole packet (until last), or is force-released after MAX_BURST beats.
- Every output beat carries the ID of its source channel.

Parameters:
- N_CH, 4: number of input channels (>=2).
- DATA_WIDTH, 512: beat width (NVDLA_PRIMARY_MEMIF_WIDTH).
- FIFO_DEPTH, 4: per-channel FIFO entries (power of 2, >=2).
- MAX_BURST, 16: maximum beats per grant before forced release (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous flush, same effect as reset.
- enable_i  in  1  when low, no new pops or grants.
- in_valid_i  in  N_CH  per-channel valid.
- in_ready_o  out  N_CH  per-channel ready (FIFO not full).
- in_data_i  in  N_CH*DATA_WIDTH  per-channel data.
- in_last_i  in  N_CH  per-channel end-of-packet.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  output ready.
- out_data_o  out  DATA_WIDTH  output data.
- out_last_o  out  1  end of packet, or end of forced burst.
- out_id_o  out  max(1,$clog2(N_CH))  source channel of the current beat.
- busy_o  out  1  any data buffered, or a grant held.

Behaviour:
- Reset/clear:
  - FIFOs empty; out_valid_o=0, out_last_o=0, out_data_o=0, out_id_o=0.
  - FSM in IDLE; rr pointer = N_CH-1, so channel 0 has first priority.
  - Beat counter = 0; busy_o=0; in_ready_o all 1 from the first cycle after reset deasserts.
  - A reset or clear mid-packet discards all buffered and in-flight beats.
- FIFO:
  - Push on in_valid_i & in_ready_o.
  - in_ready_o = !full, evaluated on registered state only. No bypass; a full FIFO stays not-ready even if popped in the same cycle.
  - Stores {data, last}.
- Output stage:
  - Single register, loaded when it is empty or being consumed (out_valid_o & out_ready_i), i.e. it is load-capable while consumed.
  - Holds data, last and id stable while out_valid_o & !out_ready_i.
- FSM IDLE:
  - When enable_i is high and the output stage is load-capable, search channels starting at pointer+1 mod N_CH and pick the first non-empty FIFO.
  - Pop its head into the output register in the same cycle, set pointer to that channel, and load counter=1.
  - If the popped beat has last=0 and MAX_BURST>1, go to LOCKED; otherwise stay in IDLE.
- FSM LOCKED:
  - Pop only from the granted channel, and only when enable_i is high, its FIFO is non-empty and the output stage is load-capable. Each pop increments the counter.
  - If the granted FIFO is empty, emit a bubble; the grant never passes to another channel mid-packet.
  - Return to IDLE when the popped beat has last=1, or when counter reaches MAX_BURST.
- out_last_o = stored last OR (counter == MAX_BURST at pop).
- Latency: a beat pushed at cycle t into an empty FIFO, with the arbiter idle and the output free, shows out_valid_o at t+2.
- Throughput: 1 beat/cycle sustained from a locked channel.
- Fairness: after a grant on channel k ends, the next search starts at k+1.
- enable_i low:
  - FIFOs keep accepting and the output register still drains.
  - No pops, the FSM holds, the counter holds.
- busy_o = any FIFO non-empty OR out_valid_o OR state==LOCKED.
- out_id_o width is 1 when N_CH=2; there is no wrap hazard at the pointer (mod N_CH).

Test Plan:
- Reset: hold rst_i 2 cycles, then release -> out_valid_o=0, busy_o=0, in_ready_o=4'b1111; channel 0 wins the first contention.
- Round robin: channels 0-3 each push one beat with last=1 at cycle 0 -> out_id_o sequence 0,1,2,3 on consecutive cycles starting at cycle 2; out_last_o=1 on every beat.
- Packet lock: ch1 pushes a 5-beat packet (last on beat 5) while ch2 has 1 beat waiting -> five ch1 beats are emitted contiguously (a bubble if ch1 starves), then the ch2 beat.
- Forced release: with MAX_BURST=16, ch0 sends a 20-beat packet and ch3 is waiting -> 16 ch0 beats with out_last_o=1 on the 16th, then ch3, then the remaining 4 ch0 beats.
- Backpressure and full: out_ready_i=0 for 10 cycles while ch2 streams -> ch2 in_ready_o drops after 4 accepted beats plus 1 in the output register; out_data_o is stable; releasing ready delivers all 5 beats in order with no loss.
- Enable/clear: enable_i=0 with data buffered -> no new out beats, in_ready_o still high until full; then clear_i mid-packet -> next cycle busy_o=0, out_valid_o=0, and channel 0 has priority again.
